scratchpad_loader: RTL and testbench



---
 rtl/scratchpad_loader_pkg.sv | 22 ++
 rtl/scratchpad_loader_areg.sv | 93 +++++++++
 rtl/scratchpad_loader.sv | 192 +++++++++++++++++++
 tb/tb_scratchpad_loader.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scratchpad_loader_pkg.sv
// Shared types and TL-UL constants for the scratchpad loader.
package scratchpad_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_e;

    localparam logic [2:0] PUT_FULL = 3'h0;
    localparam logic [2:0] GET      = 3'h4;
    localparam logic [2:0] ACK      = 3'h0;
    localparam logic [2:0] ACK_DATA = 3'h1;
    localparam logic [2:0] SIZE_64  = 3'd3;

    // D-channel opcode a well-behaved responder returns for the command direction.
    function automatic logic [2:0] expected_d_opcode(input logic is_write);
        return is_write ? ACK : ACK_DATA;
    endfunction

endpackage

// File: rtl/scratchpad_loader_areg.sv
// TL-UL A-channel holding register: one registered beat, reloaded when empty or firing.
module scratchpad_loader_areg
    import scratchpad_loader_pkg::*;
#(
    parameter int TL_AW  = 32,
    parameter int TL_DW  = 64,
    parameter int TL_AIW = 8,
    parameter int TL_SZW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic [2:0]        ld_opcode,
    input  logic [TL_AIW-1:0] ld_source,
    input  logic [TL_AW-1:0]  ld_address,
    input  logic [TL_DW-1:0]  ld_data,
    input  logic              a_ready,
    output logic              a_valid,
    output logic [2:0]        a_opcode,
    output logic [2:0]        a_param,
    output logic [TL_SZW-1:0] a_size,
    output logic [TL_AIW-1:0] a_source,
    output logic [TL_AW-1:0]  a_address,
    output logic [7:0]        a_mask,
    output logic [TL_DW-1:0]  a_data,
    output logic              a_corrupt,
    output logic              a_fire,
    output logic              load
);

    logic              avalid_q, avalid_d;
    logic [2:0]        opcode_q, opcode_d;
    logic [TL_SZW-1:0] size_q, size_d;
    logic [TL_AIW-1:0] source_q, source_d;
    logic [TL_AW-1:0]  address_q, address_d;
    logic [7:0]        mask_q, mask_d;
    logic [TL_DW-1:0]  data_q, data_d;

    assign a_fire = avalid_q & a_ready;
    assign load   = load_req & (~avalid_q | a_fire);

    always_comb begin
        avalid_d  = avalid_q;
        opcode_d  = opcode_q;
        size_d    = size_q;
        source_d  = source_q;
        address_d = address_q;
        mask_d    = mask_q;
        data_d    = data_q;
        if (load) begin
            avalid_d  = 1'b1;
            opcode_d  = ld_opcode;
            size_d    = TL_SZW'(SIZE_64);
            source_d  = ld_source;
            address_d = ld_address;
            mask_d    = 8'hFF;
            data_d    = ld_data;
        end else if (a_fire) begin
            avalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avalid_q  <= 1'b0;
            opcode_q  <= '0;
            size_q    <= '0;
            source_q  <= '0;
            address_q <= '0;
            mask_q    <= '0;
            data_q    <= '0;
        end else begin
            avalid_q  <= avalid_d;
            opcode_q  <= opcode_d;
            size_q    <= size_d;
            source_q  <= source_d;
            address_q <= address_d;
            mask_q    <= mask_d;
            data_q    <= data_d;
        end
    end

    assign a_valid   = avalid_q;
    assign a_opcode  = opcode_q;
    assign a_param   = 3'd0;
    assign a_size    = size_q;
    assign a_source  = source_q;
    assign a_address = address_q;
    assign a_mask    = mask_q;
    assign a_data    = data_q;
    assign a_corrupt = 1'b0;

endmodule

// File: rtl/scratchpad_loader.sv
// TL-UL initiator moving runs of 64-bit words between local streams and a responder.
module scratchpad_loader
    import scratchpad_loader_pkg::*;
#(
    parameter int TL_AW   = 32,
    parameter int TL_DW   = 64,
    parameter int TL_AIW  = 8,
    parameter int TL_SZW  = 2,
    parameter int MAX_OUT = 4,
    parameter int LEN_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [TL_AW-1:0]  cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [TL_DW-1:0]  wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [TL_DW-1:0]  rd_data,
    output logic [TL_AIW-1:0] rd_tag,
    output logic              done,
    output logic              err,
    output logic [2:0]        master_a_opcode,
    output logic [2:0]        master_a_param,
    output logic [TL_SZW-1:0] master_a_size,
    output logic [TL_AIW-1:0] master_a_source,
    output logic [TL_AW-1:0]  master_a_address,
    output logic [7:0]        master_a_mask,
    output logic [TL_DW-1:0]  master_a_data,
    output logic              master_a_corrupt,
    output logic              master_a_valid,
    input  logic              master_a_ready,
    input  logic [2:0]        master_d_opcode,
    input  logic [2:0]        master_d_param,
    input  logic [TL_SZW-1:0] master_d_size,
    input  logic [TL_AIW-1:0] master_d_source,
    input  logic              master_d_sink,
    input  logic              master_d_denied,
    input  logic [TL_DW-1:0]  master_d_data,
    input  logic              master_d_corrupt,
    input  logic              master_d_valid,
    output logic              master_d_ready
);

    state_e            state_q, state_d;
    logic [TL_AW-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  issued_q, issued_d;
    logic [LEN_W-1:0]  fired_q, fired_d;
    logic [LEN_W-1:0]  completed_q, completed_d;
    logic              write_q, write_d;
    logic              err_q, err_d;

    logic              busy, rd_path, d_fire, d_fire_busy, d_bad;
    logic              load_req, load, a_fire;
    logic [LEN_W:0]    in_flight;
    logic [TL_AW-1:0]  beat_addr;
    logic [TL_AIW-1:0] beat_source;
    logic [TL_DW-1:0]  beat_data;
    logic [2:0]        beat_opcode;
    logic              unused_d_fields;

    assign unused_d_fields = ^{master_d_param, master_d_size, master_d_sink};

    assign busy        = (state_q == ISSUE) || (state_q == DRAIN);
    assign rd_path     = busy && (master_d_opcode == ACK_DATA);
    assign rd_valid    = rd_path & master_d_valid;
    assign rd_data     = rd_valid ? master_d_data : '0;
    assign rd_tag      = rd_valid ? master_d_source : '0;
    assign master_d_ready = rd_path ? rd_ready : 1'b1;
    assign d_fire      = master_d_valid & master_d_ready;
    assign d_fire_busy = d_fire & busy;
    assign d_bad       = master_d_denied | master_d_corrupt |
                         (master_d_opcode != expected_d_opcode(write_q));

    // A beat firing this cycle becomes outstanding before the newly loaded one can fire,
    // so it is counted here to keep source IDs unique across the in-flight window.
    assign in_flight = {1'b0, fired_q - completed_q} + (LEN_W+1)'(a_fire);
    assign load_req  = (state_q == ISSUE) && (issued_q < len_q) &&
                       (in_flight < (LEN_W+1)'(MAX_OUT)) && (!write_q || wr_valid);
    assign wr_ready  = write_q & load;

    assign beat_addr   = addr_q + (TL_AW'(issued_q) << 3);
    assign beat_source = TL_AIW'(32'(issued_q) % MAX_OUT);
    assign beat_opcode = write_q ? PUT_FULL : GET;
    assign beat_data   = write_q ? wr_data : '0;

    scratchpad_loader_areg #(
        .TL_AW (TL_AW),
        .TL_DW (TL_DW),
        .TL_AIW(TL_AIW),
        .TL_SZW(TL_SZW)
    ) u_areg (
        .clk       (clk),
        .rst       (rst),
        .load_req  (load_req),
        .ld_opcode (beat_opcode),
        .ld_source (beat_source),
        .ld_address(beat_addr),
        .ld_data   (beat_data),
        .a_ready   (master_a_ready),
        .a_valid   (master_a_valid),
        .a_opcode  (master_a_opcode),
        .a_param   (master_a_param),
        .a_size    (master_a_size),
        .a_source  (master_a_source),
        .a_address (master_a_address),
        .a_mask    (master_a_mask),
        .a_data    (master_a_data),
        .a_corrupt (master_a_corrupt),
        .a_fire    (a_fire),
        .load      (load)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        write_d     = write_q;
        issued_d    = issued_q;
        fired_d     = fired_q;
        completed_d = completed_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d      = cmd_addr;
                    len_d       = cmd_len;
                    write_d     = cmd_write;
                    issued_d    = '0;
                    fired_d     = '0;
                    completed_d = '0;
                    err_d       = 1'b0;
                    if (cmd_len == '0) begin
                        state_d = DONE;
                    end else if (cmd_addr[2:0] != 3'd0) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE, DRAIN: begin
                issued_d    = issued_q + LEN_W'(load);
                fired_d     = fired_q + LEN_W'(a_fire);
                completed_d = completed_q + LEN_W'(d_fire_busy);
                if (d_fire_busy && d_bad) err_d = 1'b1;
                // Going straight to DONE on the last response puts done one cycle after it.
                if (completed_d == len_q) begin
                    state_d = DONE;
                end else if (state_q == ISSUE && issued_q == len_q && !master_a_valid) begin
                    state_d = DRAIN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            write_q     <= 1'b0;
            issued_q    <= '0;
            fired_q     <= '0;
            completed_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            write_q     <= write_d;
            issued_q    <= issued_d;
            fired_q     <= fired_d;
            completed_q <= completed_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign done      = (state_q == DONE);
    assign err       = done & err_q;

endmodule

// File: tb/tb_scratchpad_loader.sv
// Directed bench for scratchpad_loader with an in-order TL-UL responder model.
module tb_scratchpad_loader;
    import scratchpad_loader_pkg::*;

    localparam int TL_AW = 32, TL_DW = 64, TL_AIW = 8, TL_SZW = 2, MAX_OUT = 4, LEN_W = 16;

    logic clk = 1'b0;
    logic rst;
    logic cmd_valid, cmd_ready, cmd_write;
    logic [TL_AW-1:0] cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic wr_valid, wr_ready;
    logic [TL_DW-1:0] wr_data;
    logic rd_valid, rd_ready;
    logic [TL_DW-1:0] rd_data;
    logic [TL_AIW-1:0] rd_tag;
    logic done, err;
    logic [2:0] master_a_opcode, master_a_param;
    logic [TL_SZW-1:0] master_a_size;
    logic [TL_AIW-1:0] master_a_source;
    logic [TL_AW-1:0] master_a_address;
    logic [7:0] master_a_mask;
    logic [TL_DW-1:0] master_a_data;
    logic master_a_corrupt, master_a_valid, master_a_ready;
    logic [2:0] master_d_opcode, master_d_param;
    logic [TL_SZW-1:0] master_d_size;
    logic [TL_AIW-1:0] master_d_source;
    logic master_d_sink, master_d_denied, master_d_corrupt, master_d_valid, master_d_ready;
    logic [TL_DW-1:0] master_d_data;

    always #5 clk = ~clk;

    scratchpad_loader #(
        .TL_AW(TL_AW), .TL_DW(TL_DW), .TL_AIW(TL_AIW), .TL_SZW(TL_SZW),
        .MAX_OUT(MAX_OUT), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_tag(rd_tag),
        .done(done), .err(err),
        .master_a_opcode(master_a_opcode), .master_a_param(master_a_param),
        .master_a_size(master_a_size), .master_a_source(master_a_source),
        .master_a_address(master_a_address), .master_a_mask(master_a_mask),
        .master_a_data(master_a_data), .master_a_corrupt(master_a_corrupt),
        .master_a_valid(master_a_valid), .master_a_ready(master_a_ready),
        .master_d_opcode(master_d_opcode), .master_d_param(master_d_param),
        .master_d_size(master_d_size), .master_d_source(master_d_source),
        .master_d_sink(master_d_sink), .master_d_denied(master_d_denied),
        .master_d_data(master_d_data), .master_d_corrupt(master_d_corrupt),
        .master_d_valid(master_d_valid), .master_d_ready(master_d_ready)
    );

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  src;
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        pend[$];
    logic [31:0] a_addr_log[$];
    logic [7:0]  a_src_log[$];
    logic [63:0] a_data_log[$];
    logic [2:0]  a_op_log[$];
    logic [63:0] rd_log[$];
    logic [7:0]  rd_tag_log[$];
    logic [63:0] wr_vec[$];

    int cyc = 0;
    int lat = 1;
    int deny_at = -1;
    int resp_n, a_fires, d_fires, outst, max_outst, done_cnt, last_dfire_cyc, wr_idx;
    bit rd_toggle = 1'b0;
    int checks = 0;
    int errors = 0;

    task automatic clear_mon();
        a_fires = 0; d_fires = 0; outst = 0; max_outst = 0; done_cnt = 0;
        resp_n = 0; wr_idx = 0; last_dfire_cyc = -1;
        a_addr_log.delete(); a_src_log.delete(); a_data_log.delete(); a_op_log.delete();
        rd_log.delete(); rd_tag_log.delete();
    endtask

    // Responder, stream feeder and monitor: samples at the edge, drives 1 time unit later.
    initial begin
        master_d_valid = 1'b0; master_d_opcode = '0; master_d_param = '0; master_d_size = 2'd3;
        master_d_source = '0; master_d_sink = 1'b0; master_d_denied = 1'b0;
        master_d_data = '0; master_d_corrupt = 1'b0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;
        clear_mon();
        forever begin
            @(posedge clk);
            cyc++;
            if (master_d_valid && master_d_ready) begin
                void'(pend.pop_front());
                d_fires++; outst--; resp_n++; last_dfire_cyc = cyc;
            end
            if (rd_valid && rd_ready) begin
                rd_log.push_back(rd_data);
                rd_tag_log.push_back(rd_tag);
            end
            if (master_a_valid && master_a_ready) begin
                pend.push_back('{master_a_opcode, master_a_source, master_a_address, cyc + lat - 1});
                a_addr_log.push_back(master_a_address);
                a_src_log.push_back(master_a_source);
                a_data_log.push_back(master_a_data);
                a_op_log.push_back(master_a_opcode);
                a_fires++; outst++;
                if (outst > max_outst) max_outst = outst;
            end
            if (done) done_cnt++;
            if (wr_valid && wr_ready) wr_idx++;
            #1;
            if (pend.size() > 0 && cyc >= pend[0].due) begin
                master_d_valid  = 1'b1;
                master_d_opcode = (pend[0].op == PUT_FULL) ? ACK : ACK_DATA;
                master_d_source = pend[0].src;
                master_d_data   = (pend[0].op == GET) ? (64'hD0D0_0000_0000_0000 | 64'(pend[0].addr)) : 64'h0;
                master_d_denied = (resp_n == deny_at);
            end else begin
                master_d_valid  = 1'b0;
                master_d_denied = 1'b0;
            end
            wr_valid = (wr_idx < wr_vec.size());
            wr_data  = wr_valid ? wr_vec[wr_idx] : 64'h0;
            rd_ready = rd_toggle ? cyc[0] : 1'b1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [15:0] l, output int acc);
        logic was_ready;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
        acc = -1;
        for (int i = 0; i < 20; i++) begin
            was_ready = cmd_ready;
            step();
            if (was_ready) begin
                acc = cyc;
                break;
            end
        end
        cmd_valid = 1'b0;
        check("cmd_accepted", 64'(acc != -1), 64'd1);
    endtask

    task automatic wait_done(output int dcyc, output logic derr);
        dcyc = -1; derr = 1'bx;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                dcyc = cyc; derr = err;
                break;
            end
            step();
        end
    endtask

    int acc, dc, strays;
    logic de, pre_av;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        master_a_ready = 1'b1;
        repeat (3) step();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_d_ready", master_d_ready, 1);
        check("rst_a_valid", master_a_valid, 0);
        check("rst_done", done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_wr_ready", wr_ready, 0);
        rst = 1'b0;
        step();

        // Write of four words with a single-cycle responder.
        clear_mon();
        wr_vec = '{64'h11, 64'h22, 64'h33, 64'h44};
        step();
        send_cmd(1'b1, 32'h0, 16'd4, acc);
        check("w_avalid_at_accept", master_a_valid, 0);
        step();
        check("w_first_avalid", master_a_valid, 1);
        check("w_first_addr", master_a_address, 0);
        wait_done(dc, de);
        check("w_done_cycle", 64'(dc), 64'(last_dfire_cyc));
        check("w_err", de, 0);
        check("w_a_fires", 64'(a_fires), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("w_addr%0d", i), a_addr_log[i], 64'(8 * i));
            check($sformatf("w_src%0d", i), a_src_log[i], 64'(i));
            check($sformatf("w_data%0d", i), a_data_log[i], 64'h11 * 64'(i + 1));
            check($sformatf("w_op%0d", i), a_op_log[i], 64'(PUT_FULL));
        end
        check("w_size", master_a_size, 3);
        check("w_mask", master_a_mask, 8'hFF);
        wr_vec.delete();

        // Read of eight words, responder latency 5.
        clear_mon();
        lat = 5;
        send_cmd(1'b0, 32'h100, 16'd8, acc);
        wait_done(dc, de);
        check("r_err", de, 0);
        check("r_done_cycle", 64'(dc), 64'(last_dfire_cyc));
        check("r_max_outstanding", 64'(max_outst), 4);
        check("r_rd_count", 64'(rd_log.size()), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("r_data%0d", i), rd_log[i], 64'hD0D0_0000_0000_0000 | 64'(32'h100 + 8 * i));
            check($sformatf("r_tag%0d", i), rd_tag_log[i], 64'(i % 4));
        end

        // Read with rd_ready toggling every cycle.
        clear_mon();
        lat = 1;
        rd_toggle = 1'b1;
        step();
        send_cmd(1'b0, 32'h2000, 16'd8, acc);
        wait_done(dc, de);
        check("t_err", de, 0);
        check("t_d_fires", 64'(d_fires), 8);
        check("t_rd_count", 64'(rd_log.size()), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("t_data%0d", i), rd_log[i], 64'hD0D0_0000_0000_0000 | 64'(32'h2000 + 8 * i));
        rd_toggle = 1'b0;

        // Denied second response still completes the transfer.
        clear_mon();
        deny_at = 1;
        step();
        send_cmd(1'b0, 32'h300, 16'd3, acc);
        wait_done(dc, de);
        check("deny_err", de, 1);
        check("deny_d_fires", 64'(d_fires), 3);
        check("deny_rd_count", 64'(rd_log.size()), 3);
        deny_at = -1;

        // Misaligned address and zero length finish without bus traffic.
        clear_mon();
        step();
        send_cmd(1'b0, 32'h4, 16'd2, acc);
        wait_done(dc, de);
        check("mis_done_cycle", 64'(dc), 64'(acc));
        check("mis_err", de, 1);
        send_cmd(1'b0, 32'h40, 16'd0, acc);
        wait_done(dc, de);
        check("len0_done_cycle", 64'(dc), 64'(acc));
        check("len0_err", de, 0);
        repeat (3) step();
        check("mis_len0_a_fires", 64'(a_fires), 0);

        // Reset with two beats outstanding; stragglers must be swallowed.
        clear_mon();
        lat = 8;
        step();
        send_cmd(1'b0, 32'h400, 16'd4, acc);
        for (int i = 0; i < 50 && a_fires < 2; i++) step();
        check("rst_outstanding", 64'(outst), 2);
        pre_av = master_a_valid;
        check("rst_pre_avalid", pre_av, 1);
        rst = 1'b1;
        #1;
        check("rst_async_avalid", master_a_valid, 0);
        step();
        rst = 1'b0;
        check("rst_after_cmd_ready", cmd_ready, 1);
        strays = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (master_d_valid) begin
                strays++;
                check($sformatf("stray%0d_d_ready", strays), master_d_ready, 1);
                check($sformatf("stray%0d_rd_valid", strays), rd_valid, 0);
            end
        end
        check("stray_d_fires", 64'(d_fires), 2);
        check("stray_rd_count", 64'(rd_log.size()), 0);
        check("stray_done_cnt", 64'(done_cnt), 0);

        // A fresh command after the reset runs normally.
        clear_mon();
        lat = 1;
        wr_vec = '{64'hAA, 64'hBB};
        step();
        send_cmd(1'b1, 32'h500, 16'd2, acc);
        wait_done(dc, de);
        check("post_err", de, 0);
        check("post_a_fires", 64'(a_fires), 2);
        check("post_addr1", a_addr_log[1], 64'h508);
        check("post_src0", a_src_log[0], 0);
        check("post_data1", a_data_log[1], 64'hBB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
